event_data_monitor: RTL and testbench
=====================================

Name: event_data_monitor

Overview:
- Parametrised successor to the single-pixel final data checker.
- Sits after the readout FIFO/decoder and tracks event boundaries with a small state machine.
- Per event it counts hits, classifies events as good/empty, checks the embedded BCID against the running BCID, and checks BCID sequence continuity with orbit wrap.
- All statistics counters have configurable width and a saturate/wrap mode. A sticky overflow flag and an enable/freeze input are provided for slow-control readback.

Parameters:
- DATA_WIDTH, 29, width of TDCData word
- BCID_WIDTH, 12, width of BCID fields
- BCID_LSB, 9, bit position of embedded BCID in TDCData (field is TDCData[BCID_LSB+BCID_WIDTH-1:BCID_LSB])
- BCID_MAX, 3563, last valid BCID before wrap to 0
- CNT_WIDTH, 20, width of statistics counters
- HIT_WIDTH, 9, width of per-event hit counters
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap

Ports:
- clk  input  1  40 MHz clock
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  1 = monitor runs; 0 = all state and counters hold
- TDCData  input  DATA_WIDTH  data word, valid when hit=1
- hit  input  1  one hit word present this cycle
- eventStart  input  1  first cycle of a new event
- BCID  input  BCID_WIDTH  running bunch-crossing ID
- totalClockCount  output  CNT_WIDTH  enabled cycles since reset; always wraps
- totalGoodEventCount  output  CNT_WIDTH  closed events with ≥1 hit
- emptyEventCount  output  CNT_WIDTH  closed events with 0 hits
- orphanHitCount  output  CNT_WIDTH  hits seen in IDLE
- BCIDErrorCount  output  CNT_WIDTH  hits whose embedded BCID ≠ BCID
- BCIDSeqErrorCount  output  CNT_WIDTH  BCID discontinuities at eventStart
- hitsInLastEvent  output  HIT_WIDTH  hit count of last closed event
- maxHitsPerEvent  output  HIT_WIDTH  maximum over closed events
- inEvent  output  1  1 while FSM is in IN_EVENT
- overflowFlag  output  1  sticky; set when any counter saturates or wraps (excluding totalClockCount)

Behaviour:
- Reset: all outputs 0; FSM = IDLE; internal curHits = 0; bcidRefValid = 0. reset dominates enable and all inputs.
- enable=0: no register changes; inputs ignored.
- FSM, 2 states:
  - IDLE → IN_EVENT on eventStart.
  - IN_EVENT stays in IN_EVENT on eventStart; each eventStart closes the previous event and opens a new one.
- Event close, when eventStart=1 in IN_EVENT. Outputs update one cycle after the eventStart edge.
  - If curHits = 0: emptyEventCount += 1.
  - If curHits > 0: totalGoodEventCount += 1.
  - hitsInLastEvent <= curHits.
  - maxHitsPerEvent <= max(maxHitsPerEvent, curHits).
- Hit ownership:
  - A hit in the eventStart cycle belongs to the new event, so curHits <= hit ? 1 : 0 on that cycle.
  - Otherwise, in IN_EVENT, curHits += hit.
  - curHits saturates at all-ones regardless of SATURATE.
- Hit in IDLE (no eventStart that cycle): orphanHitCount += 1.
- BCID check: every hit, in any state, with embedded BCID ≠ BCID → BCIDErrorCount += 1.
- Sequence check, evaluated on each eventStart:
  - If bcidRefValid=1 and BCID ≠ expected → BCIDSeqErrorCount += 1.
  - expected = (bcidRef = BCID_MAX) ? 0 : bcidRef+1.
  - bcidRef <= BCID; bcidRefValid <= 1.
  - The first eventStart after reset never errors.
- Counter rule, all CNT_WIDTH counters except totalClockCount:
  - At all-ones with an increment pending: SATURATE=1 holds the value; SATURATE=0 wraps to 0.
  - Either way overflowFlag <= 1 and stays set until reset.
- Multiple increments to different counters in one cycle are independent; each counter increments by at most 1 per cycle.
- Latency: all outputs are registered, with one-cycle latency from the input edge.

Test Plan:
- reset, enable=1, 100 idle cycles → totalClockCount=100, all other counters 0, inEvent=0.
- 3 hits before any eventStart, then eventStart with no hit, 2 hits, eventStart → orphanHitCount=3, totalGoodEventCount=1, hitsInLastEvent=2, emptyEventCount=0.
- eventStart with hit=1 in the same cycle, no further hits, then eventStart → totalGoodEventCount=1, hitsInLastEvent=1. Back-to-back eventStart with no hits → emptyEventCount += 1 per extra eventStart.
- eventStart at BCID=3563 then BCID=0 → BCIDSeqErrorCount=0. eventStart at BCID=5 then BCID=7 → BCIDSeqErrorCount=1. Hit with embedded BCID 0x123 while BCID=0x124 → BCIDErrorCount=1.
- CNT_WIDTH=4, SATURATE=1: 20 empty events → emptyEventCount=15, overflowFlag=1. With SATURATE=0: emptyEventCount=4, overflowFlag=1.
- Hold enable=0 for 10 cycles with hits and eventStart toggling → no output changes. Assert reset mid-event → all outputs 0 next cycle, and the next eventStart produces no sequence error.

Source files
------------

// File: rtl/event_data_monitor.sv
// Event data monitor.
// Sits after the readout FIFO/decoder. Tracks event boundaries with a two-state
// FSM, counts hits per event, classifies closed events as good or empty,
// checks each hit's embedded BCID against the running BCID and checks BCID
// continuity (with orbit wrap) at every event start. Statistics counters
// either saturate or wrap; any such overflow sets a sticky flag.
//
// Ports:
//   clk, reset (sync, active-high), enable (0 = freeze everything)
//   TDCData/hit        : data word and its valid strobe
//   eventStart         : first cycle of a new event
//   BCID               : running bunch-crossing ID
//   totalClockCount    : enabled cycles since reset (always wraps)
//   totalGoodEventCount, emptyEventCount, orphanHitCount,
//   BCIDErrorCount, BCIDSeqErrorCount : statistics counters
//   hitsInLastEvent, maxHitsPerEvent  : per-event hit statistics
//   inEvent            : FSM is in IN_EVENT
//   overflowFlag       : sticky, any statistics counter hit all-ones with an
//                        increment pending
//
// state    | meaning
// IDLE     | no event open yet since reset; hits here are orphans
// IN_EVENT | an event is open; each eventStart closes it and opens the next
module event_data_monitor #(
    parameter int DATA_WIDTH = 29,
    parameter int BCID_WIDTH = 12,
    parameter int BCID_LSB   = 9,
    parameter int BCID_MAX   = 3563,
    parameter int CNT_WIDTH  = 20,
    parameter int HIT_WIDTH  = 9,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] TDCData,
    input  logic                  hit,
    input  logic                  eventStart,
    input  logic [BCID_WIDTH-1:0] BCID,
    output logic [CNT_WIDTH-1:0]  totalClockCount,
    output logic [CNT_WIDTH-1:0]  totalGoodEventCount,
    output logic [CNT_WIDTH-1:0]  emptyEventCount,
    output logic [CNT_WIDTH-1:0]  orphanHitCount,
    output logic [CNT_WIDTH-1:0]  BCIDErrorCount,
    output logic [CNT_WIDTH-1:0]  BCIDSeqErrorCount,
    output logic [HIT_WIDTH-1:0]  hitsInLastEvent,
    output logic [HIT_WIDTH-1:0]  maxHitsPerEvent,
    output logic                  inEvent,
    output logic                  overflowFlag
);

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_IN_EVENT = 1'b1;

    localparam logic [BCID_WIDTH-1:0] BCID_LAST = BCID_WIDTH'(BCID_MAX);

    logic                  state;
    logic [HIT_WIDTH-1:0]  cur_hits;
    logic [BCID_WIDTH-1:0] bcid_ref;
    logic                  bcid_ref_valid;

    logic                  close_evt;
    logic                  inc_good;
    logic                  inc_empty;
    logic                  inc_orphan;
    logic                  inc_bcid_err;
    logic                  inc_seq_err;
    logic                  any_overflow;
    logic [BCID_WIDTH-1:0] embedded_bcid;
    logic [BCID_WIDTH-1:0] bcid_expected;
    logic                  unused_tdc;

    // Only the BCID field of the data word is inspected.
    assign unused_tdc    = ^TDCData;
    assign embedded_bcid = TDCData[BCID_LSB +: BCID_WIDTH];
    assign bcid_expected = (bcid_ref == BCID_LAST) ? '0 : bcid_ref + BCID_WIDTH'(1);

    assign close_evt    = eventStart && (state == ST_IN_EVENT);
    assign inc_good     = close_evt && (cur_hits != '0);
    assign inc_empty    = close_evt && (cur_hits == '0);
    assign inc_orphan   = hit && !eventStart && (state == ST_IDLE);
    assign inc_bcid_err = hit && (embedded_bcid != BCID);
    assign inc_seq_err  = eventStart && bcid_ref_valid && (BCID != bcid_expected);

    assign any_overflow = (inc_good     && (&totalGoodEventCount)) ||
                          (inc_empty    && (&emptyEventCount))     ||
                          (inc_orphan   && (&orphanHitCount))      ||
                          (inc_bcid_err && (&BCIDErrorCount))      ||
                          (inc_seq_err  && (&BCIDSeqErrorCount));

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v,
                                                  input logic inc);
        if (!inc)
            return v;
        if (&v)
            return (SATURATE != 0) ? v : '0;
        return v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            cur_hits            <= '0;
            bcid_ref            <= '0;
            bcid_ref_valid      <= 1'b0;
            totalClockCount     <= '0;
            totalGoodEventCount <= '0;
            emptyEventCount     <= '0;
            orphanHitCount      <= '0;
            BCIDErrorCount      <= '0;
            BCIDSeqErrorCount   <= '0;
            hitsInLastEvent     <= '0;
            maxHitsPerEvent     <= '0;
            inEvent             <= 1'b0;
            overflowFlag        <= 1'b0;
        end else if (enable) begin
            totalClockCount     <= totalClockCount + CNT_WIDTH'(1);
            totalGoodEventCount <= bump(totalGoodEventCount, inc_good);
            emptyEventCount     <= bump(emptyEventCount, inc_empty);
            orphanHitCount      <= bump(orphanHitCount, inc_orphan);
            BCIDErrorCount      <= bump(BCIDErrorCount, inc_bcid_err);
            BCIDSeqErrorCount   <= bump(BCIDSeqErrorCount, inc_seq_err);
            if (any_overflow)
                overflowFlag <= 1'b1;

            if (eventStart) begin
                state          <= ST_IN_EVENT;
                inEvent        <= 1'b1;
                bcid_ref       <= BCID;
                bcid_ref_valid <= 1'b1;
                // A hit on the start cycle belongs to the event being opened.
                cur_hits       <= hit ? HIT_WIDTH'(1) : '0;
            end else if (state == ST_IN_EVENT && hit && !(&cur_hits)) begin
                cur_hits <= cur_hits + HIT_WIDTH'(1);
            end

            if (close_evt) begin
                hitsInLastEvent <= cur_hits;
                if (cur_hits > maxHitsPerEvent)
                    maxHitsPerEvent <= cur_hits;
            end
        end
    end

endmodule

// File: tb/tb_event_data_monitor.sv
module tb_event_data_monitor;

    localparam int DW = 29;
    localparam int BW = 12;
    localparam int BL = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] tdc_data;
    logic          hit;
    logic          event_start;
    logic [BW-1:0] bcid;

    logic [19:0] clk_cnt, good_cnt, empty_cnt, orphan_cnt, berr_cnt, seq_cnt;
    logic [8:0]  hits_last, hits_max;
    logic        in_event, ovf;

    logic [3:0]  s_clk, s_good, s_empty, s_orphan, s_berr, s_seq;
    logic [8:0]  s_last, s_max;
    logic        s_in, s_ovf;

    logic [3:0]  w_clk, w_good, w_empty, w_orphan, w_berr, w_seq;
    logic [8:0]  w_last, w_max;
    logic        w_in, w_ovf;

    always #5 clk = ~clk;

    event_data_monitor #(.DATA_WIDTH(DW), .BCID_WIDTH(BW), .BCID_LSB(BL), .BCID_MAX(3563),
                         .CNT_WIDTH(20), .HIT_WIDTH(9), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .TDCData(tdc_data), .hit(hit),
        .eventStart(event_start), .BCID(bcid),
        .totalClockCount(clk_cnt), .totalGoodEventCount(good_cnt),
        .emptyEventCount(empty_cnt), .orphanHitCount(orphan_cnt),
        .BCIDErrorCount(berr_cnt), .BCIDSeqErrorCount(seq_cnt),
        .hitsInLastEvent(hits_last), .maxHitsPerEvent(hits_max),
        .inEvent(in_event), .overflowFlag(ovf));

    event_data_monitor #(.DATA_WIDTH(DW), .BCID_WIDTH(BW), .BCID_LSB(BL), .BCID_MAX(3563),
                         .CNT_WIDTH(4), .HIT_WIDTH(9), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .TDCData(tdc_data), .hit(hit),
        .eventStart(event_start), .BCID(bcid),
        .totalClockCount(s_clk), .totalGoodEventCount(s_good),
        .emptyEventCount(s_empty), .orphanHitCount(s_orphan),
        .BCIDErrorCount(s_berr), .BCIDSeqErrorCount(s_seq),
        .hitsInLastEvent(s_last), .maxHitsPerEvent(s_max),
        .inEvent(s_in), .overflowFlag(s_ovf));

    event_data_monitor #(.DATA_WIDTH(DW), .BCID_WIDTH(BW), .BCID_LSB(BL), .BCID_MAX(3563),
                         .CNT_WIDTH(4), .HIT_WIDTH(9), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .TDCData(tdc_data), .hit(hit),
        .eventStart(event_start), .BCID(bcid),
        .totalClockCount(w_clk), .totalGoodEventCount(w_good),
        .emptyEventCount(w_empty), .orphanHitCount(w_orphan),
        .BCIDErrorCount(w_berr), .BCIDSeqErrorCount(w_seq),
        .hitsInLastEvent(w_last), .maxHitsPerEvent(w_max),
        .inEvent(w_in), .overflowFlag(w_ovf));

    // Scoreboard: expected values queued by stimulus, consumed by the monitor.
    string       q_name[$];
    int          q_sel[$];
    int unsigned q_exp[$];

    int n_checks = 0;
    int n_errors = 0;

    localparam int F_CLK = 0, F_GOOD = 1, F_EMPTY = 2, F_ORPHAN = 3, F_BERR = 4,
                   F_SEQ = 5, F_LAST = 6, F_MAX = 7, F_IN = 8, F_OVF = 9,
                   F_S_EMPTY = 10, F_S_OVF = 11, F_W_EMPTY = 12, F_W_OVF = 13;

    function automatic int unsigned observe(input int sel);
        case (sel)
            F_CLK:     return 32'(clk_cnt);
            F_GOOD:    return 32'(good_cnt);
            F_EMPTY:   return 32'(empty_cnt);
            F_ORPHAN:  return 32'(orphan_cnt);
            F_BERR:    return 32'(berr_cnt);
            F_SEQ:     return 32'(seq_cnt);
            F_LAST:    return 32'(hits_last);
            F_MAX:     return 32'(hits_max);
            F_IN:      return 32'(in_event);
            F_OVF:     return 32'(ovf);
            F_S_EMPTY: return 32'(s_empty);
            F_S_OVF:   return 32'(s_ovf);
            F_W_EMPTY: return 32'(w_empty);
            F_W_OVF:   return 32'(w_ovf);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    initial begin : monitor
        string       nm;
        int          sel;
        int unsigned ex, act;
        forever begin
            @(negedge clk);
            while (q_name.size() > 0) begin
                nm  = q_name.pop_front();
                sel = q_sel.pop_front();
                ex  = q_exp.pop_front();
                act = observe(sel);
                n_checks++;
                if (act != ex) begin
                    n_errors++;
                    $display("FAIL %s: got %0d expected %0d", nm, act, ex);
                end
            end
        end
    end

    task automatic expect_val(input string nm, input int sel, input int unsigned ex);
        q_name.push_back(nm);
        q_sel.push_back(sel);
        q_exp.push_back(ex);
    endtask

    task automatic expect_main(input string tag, input int unsigned c, input int unsigned g,
                               input int unsigned e, input int unsigned o,
                               input int unsigned b, input int unsigned s,
                               input int unsigned l, input int unsigned m,
                               input int unsigned i, input int unsigned v);
        expect_val({tag, ".clock"},  F_CLK, c);
        expect_val({tag, ".good"},   F_GOOD, g);
        expect_val({tag, ".empty"},  F_EMPTY, e);
        expect_val({tag, ".orphan"}, F_ORPHAN, o);
        expect_val({tag, ".bciderr"},F_BERR, b);
        expect_val({tag, ".seqerr"}, F_SEQ, s);
        expect_val({tag, ".last"},   F_LAST, l);
        expect_val({tag, ".max"},    F_MAX, m);
        expect_val({tag, ".inevent"},F_IN, i);
        expect_val({tag, ".ovf"},    F_OVF, v);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic es, input logic h, input int b, input int emb);
        event_start = es;
        hit         = h;
        bcid        = BW'(b);
        tdc_data    = DW'(emb) << BL;
    endtask

    initial begin : stimulus
        reset = 1'b1; enable = 1'b1;
        drive(0, 0, 0, 0);
        tick(2);
        expect_main("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        tick(100);
        expect_main("idle100", 100, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Orphans, first event with two hits.
        drive(0, 1, 10, 10); tick(3);
        drive(1, 0, 10, 10); tick(1);
        drive(0, 1, 10, 10); tick(2);
        drive(1, 0, 11, 11); tick(1);
        expect_main("orphan_evt", 107, 1, 0, 3, 0, 0, 2, 2, 1, 0);

        // Hit on the start cycle belongs to the new event; back-to-back empties.
        drive(1, 1, 12, 12); tick(1);
        expect_val("start_hit.empty", F_EMPTY, 1);
        expect_val("start_hit.last",  F_LAST, 0);
        drive(0, 0, 12, 12); tick(1);
        drive(1, 0, 13, 13); tick(1);
        expect_val("one_hit.good", F_GOOD, 2);
        expect_val("one_hit.last", F_LAST, 1);
        drive(1, 0, 14, 14); tick(1);
        drive(1, 0, 15, 15); tick(1);
        expect_main("b2b_empty", 112, 2, 3, 3, 0, 0, 0, 2, 1, 0);

        // Sequence: 15 -> 3563 is an error, 3563 -> 0 wraps cleanly.
        drive(1, 0, 3563, 0); tick(1);
        expect_val("seq_jump", F_SEQ, 1);
        drive(1, 0, 0, 0); tick(1);
        expect_val("seq_wrap", F_SEQ, 1);
        drive(1, 0, 5, 0); tick(1);
        drive(1, 0, 6, 0); tick(1);
        drive(1, 0, 8, 0); tick(1);
        expect_val("seq_gap.seq",   F_SEQ, 3);
        expect_val("seq_gap.empty", F_EMPTY, 8);

        // Embedded BCID mismatch, then a matching hit.
        drive(0, 1, 'h124, 'h123); tick(1);
        expect_val("bcid_mis", F_BERR, 1);
        drive(0, 1, 'h124, 'h124); tick(1);
        drive(1, 0, 9, 9); tick(1);
        expect_main("bcid_evt", 120, 3, 8, 3, 1, 3, 2, 2, 1, 0);

        // Larger event raises the max; a following empty event keeps it.
        drive(0, 1, 9, 9); tick(3);
        drive(1, 0, 10, 10); tick(1);
        expect_val("max3.last", F_LAST, 3);
        expect_val("max3.max",  F_MAX, 3);
        drive(1, 0, 11, 11); tick(1);
        expect_main("max_hold", 125, 4, 9, 3, 1, 3, 0, 3, 1, 0);

        // Freeze: toggling inputs while disabled changes nothing.
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(k[0], ~k[0], 777 + k, 3);
            tick(1);
        end
        expect_main("freeze", 125, 4, 9, 3, 1, 3, 0, 3, 1, 0);

        // Reset in the middle of an event.
        enable = 1'b1;
        drive(0, 1, 11, 11); tick(1);
        reset = 1'b1;
        drive(0, 0, 11, 11); tick(1);
        expect_main("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(1, 0, 500, 0); tick(1);
        expect_val("post_reset.seq", F_SEQ, 0);
        expect_val("post_reset.in",  F_IN, 1);
        drive(1, 0, 700, 0); tick(1);
        expect_val("post_reset2.seq",   F_SEQ, 1);
        expect_val("post_reset2.empty", F_EMPTY, 1);

        // 21 starts = 20 closed empty events on every instance.
        reset = 1'b1; drive(0, 0, 0, 0); tick(1);
        reset = 1'b0;
        for (int k = 0; k < 21; k++) begin
            drive(1, 0, 100 + k, 0);
            tick(1);
        end
        drive(0, 0, 120, 0); tick(1);
        expect_val("sat.empty",  F_S_EMPTY, 15);
        expect_val("sat.ovf",    F_S_OVF, 1);
        expect_val("wrap.empty", F_W_EMPTY, 4);
        expect_val("wrap.ovf",   F_W_OVF, 1);
        expect_val("wide.empty", F_EMPTY, 20);
        expect_val("wide.ovf",   F_OVF, 0);
        expect_val("wide.seq",   F_SEQ, 0);

        for (int k = 0; k < 20 && q_name.size() > 0; k++)
            @(negedge clk);
        if (q_name.size() > 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q_name.size());
        end
        tick(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
